// File: rtl/gray_ptr_sync_if.sv
// gray_ptr_sync_if
//   Groups the pointer-synchronizer signals into one bundle.
//   The clock and reset are not part of the bundle.
//
//   Signals (all PTR_WIDTH+1 bits unless noted):
//     gray_in   Gray pointer from the source domain (asynchronous to clk)
//     err_clr   1 bit, synchronous clear of err
//     gray_out  synchronized Gray pointer
//     bin_out   binary equivalent of gray_out
//     changed   1 bit, strobe: gray_out took a new value this cycle
//     delta     binary advance of this update, modulo 2^(PTR_WIDTH+1)
//     err       1 bit, sticky multi-bit Gray change flag
//
//   Modports:
//     master  the side that supplies gray_in/err_clr and consumes the results
//     slave   the synchronizer itself
interface gray_ptr_sync_if #(
  parameter int PTR_WIDTH = 5
);
  logic [PTR_WIDTH:0] gray_in;
  logic               err_clr;
  logic [PTR_WIDTH:0] gray_out;
  logic [PTR_WIDTH:0] bin_out;
  logic               changed;
  logic [PTR_WIDTH:0] delta;
  logic               err;

  modport master (
    output gray_in, err_clr,
    input  gray_out, bin_out, changed, delta, err
  );

  modport slave (
    input  gray_in, err_clr,
    output gray_out, bin_out, changed, delta, err
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
//   Destination-domain synchronizer for a Gray-coded FIFO pointer.
//   gray_in passes through a STAGES-deep flop chain, then one output
//   register stage produces the Gray value, its binary form, a change
//   strobe, the binary advance since the previous value and a sticky error
//   flag for captures that moved more than one Gray bit at once.
//
//   Parameters:
//     PTR_WIDTH  pointer index width; buses are PTR_WIDTH+1 bits
//     STAGES     synchronizer depth, 2..4
//
//   Ports:
//     clk    destination-domain clock
//     rst_n  asynchronous assert, synchronous release, active-low reset
//     bus    gray_ptr_sync_if.slave (gray_in, err_clr in; gray_out, bin_out,
//            changed, delta, err out -- all outputs registered)
module gray_ptr_sync #(
  parameter int PTR_WIDTH = 5,
  parameter int STAGES    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_ptr_sync_if.slave      bus
);

  localparam int W = PTR_WIDTH + 1;

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("gray_ptr_sync: STAGES must be in 2..4");
    end
  endgenerate

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchronizer chain: plain flop-to-flop, nothing in between.
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_reg [STAGES];

  logic [W-1:0] gray_out_reg;
  logic [W-1:0] bin_out_reg;
  logic         changed_reg;
  logic [W-1:0] delta_reg;
  logic         err_reg;

  logic [W-1:0] sync_last;
  logic [W-1:0] bin_next;
  logic [W-1:0] diff;
  logic         multi_bit;
  logic         err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= bus.gray_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  always_comb begin
    sync_last = sync_reg[STAGES-1];
    bin_next  = g2b(sync_last);
    diff      = sync_last ^ gray_out_reg;
    // x & (x-1) clears the lowest set bit; anything left means >1 bit moved.
    multi_bit = (diff & (diff - 1'b1)) != '0;
    // A new set condition outranks a simultaneous clear.
    if (multi_bit) begin
      err_next = 1'b1;
    end else if (bus.err_clr) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  // bin_out_reg always holds g2b(gray_out_reg), so it serves as the previous
  // binary value for delta without a second converter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_out_reg <= '0;
      bin_out_reg  <= '0;
      changed_reg  <= 1'b0;
      delta_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      gray_out_reg <= sync_last;
      bin_out_reg  <= bin_next;
      changed_reg  <= (diff != '0);
      delta_reg    <= bin_next - bin_out_reg;
      err_reg      <= err_next;
    end
  end

  assign bus.gray_out = gray_out_reg;
  assign bus.bin_out  = bin_out_reg;
  assign bus.changed  = changed_reg;
  assign bus.delta    = delta_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync
//   Directed bench for gray_ptr_sync. Three instances (STAGES = 2, 3, 4)
//   share the same stimulus; detailed checks use the STAGES=2 instance,
//   latency is compared across all three.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] gray_in;
  logic       err_clr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gray_ptr_sync_if #(.PTR_WIDTH(5)) if2 ();
  gray_ptr_sync_if #(.PTR_WIDTH(5)) if3 ();
  gray_ptr_sync_if #(.PTR_WIDTH(5)) if4 ();

  assign if2.gray_in = gray_in;
  assign if3.gray_in = gray_in;
  assign if4.gray_in = gray_in;
  assign if2.err_clr = err_clr;
  assign if3.err_clr = err_clr;
  assign if4.err_clr = err_clr;

  gray_ptr_sync #(.PTR_WIDTH(5), .STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  gray_ptr_sync #(.PTR_WIDTH(5), .STAGES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  gray_ptr_sync #(.PTR_WIDTH(5), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] b2g(input int k);
    logic [5:0] v;
    v = k[5:0];
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    gray_in = 6'd0;
    err_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
  endtask

  int lat2, lat3, lat4;

  initial begin
    // Reset with a nonzero input held.
    rst_n   = 1'b0;
    gray_in = 6'b000011;
    err_clr = 1'b0;
    tick(3);
    check("rst_gray",    32'(if2.gray_out), 32'h0);
    check("rst_bin",     32'(if2.bin_out),  32'h0);
    check("rst_changed", 32'(if2.changed),  32'h0);
    check("rst_delta",   32'(if2.delta),    32'h0);
    check("rst_err",     32'(if2.err),      32'h0);
    rst_n = 1'b1;
    tick(2);
    check("rel_e2_gray", 32'(if2.gray_out), 32'h0);
    tick(1);
    check("rel_e3_gray",    32'(if2.gray_out), 32'h03);
    check("rel_e3_bin",     32'(if2.bin_out),  32'h02);
    check("rel_e3_changed", 32'(if2.changed),  32'h1);
    check("rel_e3_delta",   32'(if2.delta),    32'h2);
    tick(1);
    check("rel_e4_changed", 32'(if2.changed), 32'h0);
    check("rel_e4_delta",   32'(if2.delta),   32'h0);

    // Incrementing sweep 1..63 then wrap to 0, one code per 4 cycles.
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      gray_in = b2g(k % 64);
      tick(3);
      check($sformatf("sweep%0d_bin", k),     32'(if2.bin_out), 32'(k % 64));
      check($sformatf("sweep%0d_changed", k), 32'(if2.changed), 32'h1);
      check($sformatf("sweep%0d_delta", k),   32'(if2.delta),   32'h1);
      tick(1);
    end
    check("sweep_err", 32'(if2.err), 32'h0);

    // Latency per depth, counting the capture edge as edge 1.
    do_reset();
    gray_in = 6'b000001;
    lat2 = 0; lat3 = 0; lat4 = 0;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (lat2 == 0 && if2.bin_out == 6'd1) lat2 = e;
      if (lat3 == 0 && if3.bin_out == 6'd1) lat3 = e;
      if (lat4 == 0 && if4.bin_out == 6'd1) lat4 = e;
    end
    check("lat_stages2", 32'(lat2), 32'd3);
    check("lat_stages3", 32'(lat3), 32'd4);
    check("lat_stages4", 32'(lat4), 32'd5);

    // Illegal 2-bit jump 000000 -> 000011.
    do_reset();
    gray_in = 6'b000011;
    tick(2);
    check("jump_pre_err", 32'(if2.err), 32'h0);
    tick(1);
    check("jump_err",   32'(if2.err),     32'h1);
    check("jump_bin",   32'(if2.bin_out), 32'h02);
    check("jump_delta", 32'(if2.delta),   32'h2);
    tick(20);
    check("jump_err_sticky", 32'(if2.err), 32'h1);

    // Clear alone, then clear with err already low.
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("clr_alone", 32'(if2.err), 32'h0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("clr_noop_err", 32'(if2.err),     32'h0);
    check("clr_noop_bin", 32'(if2.bin_out), 32'h02);

    // Clear coincident with a new 2-bit change (000011 -> 000101): set wins.
    gray_in = 6'b000101;
    tick(2);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("clr_vs_set_err",   32'(if2.err),     32'h1);
    check("clr_vs_set_bin",   32'(if2.bin_out), 32'h06);
    check("clr_vs_set_delta", 32'(if2.delta),   32'h4);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("clr_after", 32'(if2.err), 32'h0);

    // Mid-operation asynchronous reset with a pending 000101 -> 000100 step.
    gray_in = 6'b000100;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gray",    32'(if2.gray_out), 32'h0);
    check("midrst_bin",     32'(if2.bin_out),  32'h0);
    check("midrst_changed", 32'(if2.changed),  32'h0);
    check("midrst_delta",   32'(if2.delta),    32'h0);
    tick(2);
    check("midrst_hold_changed", 32'(if2.changed), 32'h0);
    rst_n = 1'b1;
    tick(2);
    check("midrst_rel_gray",    32'(if2.gray_out), 32'h0);
    check("midrst_rel_changed", 32'(if2.changed),  32'h0);
    tick(1);
    check("midrst_resync_gray",    32'(if2.gray_out), 32'h04);
    check("midrst_resync_bin",     32'(if2.bin_out),  32'h07);
    check("midrst_resync_delta",   32'(if2.delta),    32'h7);
    check("midrst_resync_changed", 32'(if2.changed),  32'h1);
    check("midrst_resync_err",     32'(if2.err),      32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
